// File: rtl/slt_pkg.sv
// Shared opcode definitions for the set-less-than unit.
// Both compare-mode codes are exported as an enum and as plain localparams.
package slt_pkg;

    localparam logic [3:0] SLT_CODE  = 4'b0010;
    localparam logic [3:0] SLTU_CODE = 4'b0011;

    typedef enum logic [3:0] {
        OP_SLT  = SLT_CODE,
        OP_SLTU = SLTU_CODE
    } slt_op_e;

endpackage

// File: rtl/slt_comparator.sv
// Combinational less-than built on one shared subtractor.
// Unsigned uses the borrow out; signed uses result sign XOR overflow.
module slt_comparator #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic                  is_signed,
    output logic                  lt
);

    logic [DATA_WIDTH:0]   wide_diff;
    logic [DATA_WIDTH-1:0] diff;
    logic                  borrow;
    logic                  overflow;
    logic                  nonzero;

    assign wide_diff = {1'b0, SrcA} - {1'b0, SrcB};
    assign borrow    = wide_diff[DATA_WIDTH];
    assign diff      = wide_diff[DATA_WIDTH-1:0];
    assign overflow  = (SrcA[DATA_WIDTH-1] != SrcB[DATA_WIDTH-1]) &&
                       (diff[DATA_WIDTH-1] != SrcA[DATA_WIDTH-1]);
    // Equal operands are forced to "not less than" explicitly in both modes.
    assign nonzero   = |diff;

    always_comb begin
        lt = 1'b0;
        if (nonzero) begin
            if (is_signed) lt = diff[DATA_WIDTH-1] ^ overflow;
            else           lt = borrow;
        end
    end

endmodule

// File: rtl/slt_operation.sv
// SLT/SLTU execute-stage unit: decode, compare, and one-cycle result register.
// Unknown opcodes still produce a registered zero with a valid strobe.
module slt_operation
    import slt_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic                     in_valid,
    output logic [DATA_WIDTH-1:0]    Rd,
    output logic                     out_valid
);

    logic is_signed;
    logic op_known;
    logic cmp_lt;
    logic lt;

    always_comb begin
        is_signed = 1'b0;
        op_known  = 1'b0;
        if (Operation == OPCODE_LENGTH'(OP_SLT)) begin
            is_signed = 1'b1;
            op_known  = 1'b1;
        end else if (Operation == OPCODE_LENGTH'(OP_SLTU)) begin
            op_known  = 1'b1;
        end
    end

    slt_comparator #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .is_signed (is_signed),
        .lt        (cmp_lt)
    );

    assign lt = cmp_lt & op_known;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Rd        <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) Rd <= {{(DATA_WIDTH-1){1'b0}}, lt};
        end
    end

endmodule

// File: tb/tb_slt_operation.sv
// Directed plus random bench for slt_operation with a queue scoreboard.
// Expected results are pushed at drive time and popped one cycle later.
module tb_slt_operation;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] SrcA, SrcB;
    logic [3:0]  Operation;
    logic        in_valid;
    logic [31:0] Rd;
    logic        out_valid;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    slt_operation #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Operation (Operation),
        .in_valid  (in_valid),
        .Rd        (Rd),
        .out_valid (out_valid)
    );

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        logic r;
        case (op)
            4'b0010: r = ($signed(a) < $signed(b));
            4'b0011: r = (a < b);
            default: r = 1'b0;
        endcase
        return {31'b0, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic iv);
        logic [31:0] e;
        rst_n = 1'b1; SrcA = a; SrcB = b; Operation = op; in_valid = iv;
        if (iv) exp_q.push_back(model(a, b, op));
        @(posedge clk); #1;
        check({tag, ".vld"}, {31'b0, out_valid}, {31'b0, iv});
        if (iv) begin
            if (exp_q.size() == 0) begin
                check({tag, ".empty"}, 32'd1, 32'd0);
                e = 32'hx;
            end else e = exp_q.pop_front();
        end else e = last_rd;
        check({tag, ".rd"}, Rd, e);
        last_rd = e;
    endtask

    task automatic rst_cyc(input string tag, input logic iv);
        rst_n = 1'b0; SrcA = 32'h5; SrcB = 32'hA; Operation = 4'b0010; in_valid = iv;
        @(posedge clk); #1;
        exp_q.delete();
        last_rd = 32'h0;
        check({tag, ".vld"}, {31'b0, out_valid}, 32'd0);
        check({tag, ".rd"}, Rd, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; SrcA = '0; SrcB = '0; Operation = 4'b0010; in_valid = 1'b0;
        last_rd = '0;
        rst_cyc("rst0", 1'b1);
        rst_cyc("rst1", 1'b1);

        cyc("slt_5_10",   32'h5, 32'hA, 4'b0010, 1'b1);
        cyc("slt_10_5",   32'hA, 32'h5, 4'b0010, 1'b1);
        cyc("slt_m1_1",   32'hFFFFFFFF, 32'h1, 4'b0010, 1'b1);
        cyc("sltu_m1_1",  32'hFFFFFFFF, 32'h1, 4'b0011, 1'b1);
        cyc("slt_min_max",  32'h80000000, 32'h7FFFFFFF, 4'b0010, 1'b1);
        cyc("slt_max_min",  32'h7FFFFFFF, 32'h80000000, 4'b0010, 1'b1);
        cyc("sltu_max_min", 32'h7FFFFFFF, 32'h80000000, 4'b0011, 1'b1);
        cyc("slt_eq",     32'h12345678, 32'h12345678, 4'b0010, 1'b1);
        cyc("sltu_eq",    32'h12345678, 32'h12345678, 4'b0011, 1'b1);
        cyc("sltu_1_2",   32'h1, 32'h2, 4'b0011, 1'b1);
        cyc("badop",      32'h1, 32'h2, 4'b1111, 1'b1);
        cyc("badop0",     32'h1, 32'h2, 4'b0000, 1'b1);

        // Alternating results back to back, then hold with garbage operands.
        cyc("b2b0", 32'h1, 32'h2, 4'b0010, 1'b1);
        cyc("b2b1", 32'h2, 32'h1, 4'b0010, 1'b1);
        cyc("b2b2", 32'h1, 32'h2, 4'b0011, 1'b1);
        cyc("b2b3", 32'h2, 32'h1, 4'b0011, 1'b1);
        cyc("b2b4", 32'h1, 32'h2, 4'b0010, 1'b1);
        cyc("hold0", 32'h2, 32'h1, 4'b0010, 1'b0);
        cyc("hold1", 32'hFFFFFFFF, 32'h0, 4'b0011, 1'b0);

        cyc("pre_rst", 32'h80000000, 32'h0, 4'b0010, 1'b1);
        cyc("pre_rst2", 32'h0, 32'h1, 4'b0011, 1'b1);
        rst_cyc("mid_rst", 1'b1);
        cyc("post_rst", 32'h3, 32'h4, 4'b0011, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            logic [3:0]  op;
            a  = $urandom;
            b  = (i % 5 == 0) ? a : $urandom;
            if (i % 7 == 1) b = {~a[31], a[30:0]};
            op = (i % 9 == 4) ? 4'($urandom_range(0, 15)) : ((i % 2 == 0) ? 4'b0010 : 4'b0011);
            cyc("rnd", a, b, op, ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
